// File: rtl/bit_counter_pkg.sv
// Shared types and constants for the multimode bit counter.
// Holds the controller state encoding, mode codes and width check.
package bit_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_ONES  = 2'b00;
  localparam logic [1:0] MODE_ZEROS = 2'b01;
  localparam logic [1:0] MODE_TZ    = 2'b10;

  typedef struct packed {
    logic load;
    logic shift;
    logic inc;
  } ctrl_t;

  typedef struct packed {
    logic a_zero;
    logic a_lsb;
    logic iter_max;
    logic tz_mode;
  } stat_t;

  // Result must hold the largest possible count, A_WIDTH.
  function automatic bit width_ok(input int aw, input int rw);
    return rw >= $clog2(aw + 1);
  endfunction

endpackage

// File: rtl/bit_counter_datapath.sv
// Operand shifter, count and iteration registers of the bit counter.
// Zero-count mode loads the inverted operand so it reuses popcount.
module bit_counter_datapath
  import bit_counter_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int RET_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 inc,
  input  logic [1:0]           mode_in,
  input  logic [A_WIDTH-1:0]   a_in,
  output logic                 a_zero,
  output logic                 a_lsb,
  output logic                 iter_max,
  output logic                 tz_mode,
  output logic [RET_WIDTH-1:0] result
);

  logic [A_WIDTH-1:0]   r_a;
  logic [RET_WIDTH-1:0] r_result;
  logic [RET_WIDTH-1:0] r_iter;
  logic [1:0]           r_mode;
  logic                 w_tz;
  logic [RET_WIDTH-1:0] w_step;

  assign w_tz   = (r_mode == MODE_TZ);
  assign w_step = w_tz ? RET_WIDTH'(1)
                       : RET_WIDTH'(r_a[0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_result <= '0;
      r_iter   <= '0;
      r_mode   <= '0;
    end else if (load) begin
      r_a      <= (mode_in == MODE_ZEROS) ? ~a_in : a_in;
      r_mode   <= mode_in;
      r_result <= '0;
      r_iter   <= '0;
    end else begin
      if (shift) begin
        r_a <= r_a >> 1;
      end
      if (inc) begin
        r_result <= r_result + w_step;
        if (w_tz) begin
          r_iter <= r_iter + RET_WIDTH'(1);
        end
      end
    end
  end

  assign a_zero   = (r_a == '0);
  assign a_lsb    = r_a[0];
  assign iter_max = (r_iter == RET_WIDTH'(A_WIDTH));
  assign tz_mode  = w_tz;
  assign result   = r_result;

endmodule

// File: rtl/bit_counter_multimode.sv
// Start/done handshaked bit counter: ones, zeros or trailing zeros.
// Controller FSM here; one operand bit is consumed per COUNT cycle.
module bit_counter_multimode
  import bit_counter_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int RET_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 s,
  input  logic [1:0]           mode,
  input  logic [A_WIDTH-1:0]   A,
  output logic [RET_WIDTH-1:0] result,
  output logic                 busy,
  output logic                 done
);

  if (!width_ok(A_WIDTH, RET_WIDTH)) begin : g_width_chk
    $error("RET_WIDTH too small for A_WIDTH");
  end

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  stat_t  w_stat;
  logic   w_finish;

  bit_counter_datapath #(
    .A_WIDTH   (A_WIDTH),
    .RET_WIDTH (RET_WIDTH)
  ) u_dp (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (w_ctrl.load),
    .shift    (w_ctrl.shift),
    .inc      (w_ctrl.inc),
    .mode_in  (mode),
    .a_in     (A),
    .a_zero   (w_stat.a_zero),
    .a_lsb    (w_stat.a_lsb),
    .iter_max (w_stat.iter_max),
    .tz_mode  (w_stat.tz_mode),
    .result   (result)
  );

  // Trailing-zero runs stop on a set LSB or after A_WIDTH shifts.
  assign w_finish = w_stat.tz_mode
                  ? (w_stat.a_lsb | w_stat.iter_max)
                  : w_stat.a_zero;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (s) begin
          w_next = S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_finish) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!s) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        w_ctrl.load = ~s;
      end
      (r_state == S_COUNT): begin
        busy         = 1'b1;
        w_ctrl.shift = ~w_finish;
        w_ctrl.inc   = ~w_finish;
      end
      (r_state == S_DONE): begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
